// File: rtl/mem_master_pkg.sv
// Shared definitions for the mem_master block.
// Holds the access-size encodings, the FSM state encoding, the default widths,
// and a helper that maps an access size to its byte count.
package mem_master_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_SIZE       = 1024;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_ILL = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRd   = 2'd1,
        StWr   = 2'd2,
        StResp = 2'd3
    } state_e;

    // Byte count of an access; the illegal encoding maps to 4 but is rejected anyway.
    function automatic logic [2:0] size_bytes(size_e sz);
        unique case (sz)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_master_if.sv
// Bundle of the request, response and memory-port signals of mem_master.
// modport master: the mem_master view (drives req_ready, rsp_*, mem_* outputs).
// modport slave : the environment view (drives requests, rsp_ready, mem_data_r).
interface mem_master_if
    import mem_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  mem_op;
    logic                  mem_rw;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_w;
    logic [DATA_WIDTH-1:0] mem_data_r;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready, mem_data_r,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_op, mem_rw, mem_addr, mem_data_w
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready, mem_data_r,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_op, mem_rw, mem_addr, mem_data_w
    );

endinterface

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatter for mem_master.
// Ports: size/is_unsigned select the access; rdata is the word read from memory,
// wdata the store data. load_data is the extracted, extended load result; merged is
// rdata with its low byte/half replaced by wdata (the read-modify-write word).
module mem_lane_fmt
    import mem_master_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  size_e                 size,
    input  logic                  is_unsigned,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] merged
);

    logic sext_b;
    logic sext_h;

    assign sext_b = ~is_unsigned & rdata[7];
    assign sext_h = ~is_unsigned & rdata[15];

    always_comb begin
        load_data = rdata;
        merged    = wdata;
        unique case (size)
            SZ_B: begin
                load_data = {{(DATA_WIDTH-8){sext_b}}, rdata[7:0]};
                merged    = {rdata[DATA_WIDTH-1:8], wdata[7:0]};
            end
            SZ_H: begin
                load_data = {{(DATA_WIDTH-16){sext_h}}, rdata[15:0]};
                merged    = {rdata[DATA_WIDTH-1:16], wdata[15:0]};
            end
            default: begin
                load_data = rdata;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_master.sv
// Single-outstanding load/store master in front of a byte-addressed memory.
// Ports: sys_clk, sys_rst (async, active-low); bus carries the request channel
// (req_*), the response channel (rsp_*) and the registered memory port (mem_*).
// Sub-byte stores are done as read-modify-write of the containing word.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned SIZE       = DEF_SIZE
) (
    input logic          sys_clk,
    input logic          sys_rst,
    mem_master_if.master bus
);

    state_e                state_q, state_d;
    size_e                 size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  mem_op_q, mem_op_d;
    logic                  mem_rw_q, mem_rw_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_w_q, mem_data_w_d;

    size_e                 req_size;
    logic [ADDR_WIDTH:0]   req_end;
    logic                  req_err;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged_data;

    assign req_size = size_e'(bus.req_size);
    // One extra bit so addresses near the top of the space cannot wrap into range.
    assign req_end  = {1'b0, bus.req_addr}
                    + {{(ADDR_WIDTH-2){1'b0}}, size_bytes(req_size)};
    assign req_err  = (req_size == SZ_ILL) || (req_end > (ADDR_WIDTH+1)'(SIZE));

    mem_lane_fmt #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_fmt (
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .rdata       (bus.mem_data_r),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged_data)
    );

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        mem_op_d     = 1'b0;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_data_w_d = mem_data_w_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    size_d      = req_size;
                    unsigned_d  = bus.req_unsigned;
                    we_d        = bus.req_we;
                    wdata_d     = bus.req_wdata;
                    rsp_rdata_d = '0;
                    rsp_err_d   = req_err;
                    if (req_err) begin
                        state_d = StResp;
                    end else if (bus.req_we && (req_size == SZ_W)) begin
                        state_d      = StWr;
                        mem_op_d     = 1'b1;
                        mem_rw_d     = 1'b1;
                        mem_addr_d   = bus.req_addr;
                        mem_data_w_d = bus.req_wdata;
                    end else begin
                        // Loads and sub-word stores both start with a read.
                        state_d    = StRd;
                        mem_op_d   = 1'b1;
                        mem_rw_d   = 1'b0;
                        mem_addr_d = bus.req_addr;
                    end
                end
            end
            StRd: begin
                if (we_q) begin
                    state_d      = StWr;
                    mem_op_d     = 1'b1;
                    mem_rw_d     = 1'b1;
                    mem_data_w_d = merged_data;
                end else begin
                    state_d     = StResp;
                    rsp_rdata_d = load_data;
                end
            end
            StWr: begin
                state_d = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q      <= StIdle;
            size_q       <= SZ_B;
            unsigned_q   <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            mem_op_q     <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_w_q <= '0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            mem_op_q     <= mem_op_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_w_q <= mem_data_w_d;
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.rsp_valid  = (state_q == StResp);
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.mem_op     = mem_op_q;
    assign bus.mem_rw     = mem_rw_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_data_w = mem_data_w_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: a byte-array memory acting on negedge, a shadow
// memory as reference model, and a scoreboard queue of expected responses.
module tb_mem_master;
    import mem_master_pkg::*;

    localparam int unsigned AW        = 32;
    localparam int unsigned DW        = 32;
    localparam int unsigned MEM_BYTES = 1024;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst;

    mem_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .SIZE       (MEM_BYTES)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    initial forever #5 sys_clk = ~sys_clk;

    logic [7:0]  mem     [MEM_BYTES];
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [31:0] rd_data = 32'h0;
    logic [31:0] last_wr = 32'h0;
    int          rd_pulses = 0;
    int          wr_pulses = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        sb[$];

    assign bus.mem_data_r = rd_data;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return (a < 32'(MEM_BYTES)) ? mem[a[9:0]] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return (a < 32'(MEM_BYTES)) ? ref_mem[a[9:0]] : 8'h00;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 3), mem_byte(a + 2), mem_byte(a + 1), mem_byte(a)};
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_byte(a + 3), ref_byte(a + 2), ref_byte(a + 1), ref_byte(a)};
    endfunction

    // Memory: acts on negedge while mem_op is high and holds the read result.
    always @(negedge sys_clk) begin
        if (bus.mem_op === 1'b1) begin
            if (bus.mem_rw) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.mem_addr + 32'(i) < 32'(MEM_BYTES)) begin
                        mem[10'(bus.mem_addr + 32'(i))] = bus.mem_data_w[8*i +: 8];
                    end
                end
                last_wr   = bus.mem_data_w;
                wr_pulses = wr_pulses + 1;
            end else begin
                rd_data   = mem_word(bus.mem_addr);
                rd_pulses = rd_pulses + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ":req_ready"},  32'(bus.req_ready), 32'd1);
        chk({tag, ":rsp_valid"},  32'(bus.rsp_valid), 32'd0);
        chk({tag, ":rsp_err"},    32'(bus.rsp_err), 32'd0);
        chk({tag, ":rsp_rdata"},  bus.rsp_rdata, 32'd0);
        chk({tag, ":mem_op"},     32'(bus.mem_op), 32'd0);
        chk({tag, ":mem_rw"},     32'(bus.mem_rw), 32'd0);
        chk({tag, ":mem_addr"},   bus.mem_addr, 32'd0);
        chk({tag, ":mem_data_w"}, bus.mem_data_w, 32'd0);
    endtask

    // Issue one request, wait for its response (optionally stalling rsp_ready for
    // 'hold' cycles), and check data, latency, pulse counts and memory effect.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold);
        exp_t        e;
        exp_t        got;
        int          nb;
        int          lat;
        int          rd0;
        int          wr0;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] w;

        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        e.err   = (size == 2'd3) || (({1'b0, addr} + 33'(nb)) > 33'(MEM_BYTES));
        e.rdata = 32'h0;
        if (!e.err && !we) begin
            w = ref_word(addr);
            case (size)
                2'd0:    e.rdata = uns ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
                2'd1:    e.rdata = uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
                default: e.rdata = w;
            endcase
        end
        sb.push_back(e);
        exp_lat = e.err ? 1 : (we && size != 2'd2) ? 3 : 2;
        exp_rd  = (e.err || (we && size == 2'd2)) ? 0 : 1;
        exp_wr  = (!e.err && we) ? 1 : 0;
        rd0 = rd_pulses;
        wr0 = wr_pulses;

        chk({tag, ":req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge sys_clk);
        #1;
        // Junk on the request inputs must be ignored once accepted.
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom_range(0, 1));
        bus.req_size     = 2'($urandom_range(0, 3));
        bus.req_unsigned = 1'($urandom_range(0, 1));
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;

        lat = 0;
        do begin
            @(negedge sys_clk);
            lat++;
        end while (bus.rsp_valid !== 1'b1 && lat < 20);
        chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        got = sb.pop_front();

        if (bus.rsp_valid === 1'b1) begin
            for (int c = 0; c < hold; c++) begin
                @(negedge sys_clk);
                chk({tag, ":hold_valid"}, 32'(bus.rsp_valid), 32'd1);
                chk({tag, ":hold_rdata"}, bus.rsp_rdata, got.rdata);
                chk({tag, ":hold_req_ready"}, 32'(bus.req_ready), 32'd0);
            end
            chk({tag, ":rdata"}, bus.rsp_rdata, got.rdata);
            chk({tag, ":err"}, 32'(bus.rsp_err), 32'(got.err));
            bus.rsp_ready = 1'b1;
            @(posedge sys_clk);
            #1;
            bus.rsp_ready = 1'b0;
            chk({tag, ":idle_req_ready"}, 32'(bus.req_ready), 32'd1);
            chk({tag, ":idle_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        end

        chk({tag, ":rd_pulses"}, 32'(rd_pulses - rd0), 32'(exp_rd));
        chk({tag, ":wr_pulses"}, 32'(wr_pulses - wr0), 32'(exp_wr));
        if (we && !e.err) begin
            for (int i = 0; i < nb; i++) begin
                if (addr + 32'(i) < 32'(MEM_BYTES)) begin
                    ref_mem[10'(addr + 32'(i))] = wdata[8*i +: 8];
                end
            end
            chk({tag, ":mem_data_w"}, last_wr, ref_word(addr));
            chk({tag, ":mem_word"}, mem_word(addr), ref_word(addr));
        end
    endtask

    initial begin
        for (int i = 0; i < int'(MEM_BYTES); i++) begin
            mem[i]     = 8'(i * 37 + 11);
            ref_mem[i] = 8'(i * 37 + 11);
        end
        // Word 0x00100513 at 0x0 and byte 0x93 at 0x8.
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00; mem[8] = 8'h93;
        ref_mem[0] = 8'h13; ref_mem[1] = 8'h05; ref_mem[2] = 8'h10; ref_mem[3] = 8'h00;
        ref_mem[8] = 8'h93;

        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.rsp_ready    = 1'b0;
        sys_rst          = 1'b1;
        #1 sys_rst = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;

        do_req("lw_0",        1'b0, 2'd2, 1'b0, 32'h0,   32'h0, 0);
        do_req("lb_8",        1'b0, 2'd0, 1'b0, 32'h8,   32'h0, 0);
        do_req("lbu_8",       1'b0, 2'd0, 1'b1, 32'h8,   32'h0, 0);
        do_req("lh_1",        1'b0, 2'd1, 1'b0, 32'h1,   32'h0, 0);
        do_req("sw_40",       1'b1, 2'd2, 1'b0, 32'h40,  32'h11223344, 0);
        do_req("sh_40",       1'b1, 2'd1, 1'b0, 32'h40,  32'h0000BEEF, 0);
        do_req("lw_40",       1'b0, 2'd2, 1'b0, 32'h40,  32'h0, 0);
        do_req("sw_80",       1'b1, 2'd2, 1'b0, 32'h80,  32'h8001F00D, 0);
        do_req("lh_80",       1'b0, 2'd1, 1'b0, 32'h80,  32'h0, 0);
        do_req("lhu_80",      1'b0, 2'd1, 1'b1, 32'h80,  32'h0, 0);
        do_req("sb_83",       1'b1, 2'd0, 1'b0, 32'h83,  32'hFFFFFF7E, 0);
        do_req("lw_80",       1'b0, 2'd2, 1'b0, 32'h80,  32'h0, 0);
        do_req("lw_1022_err", 1'b0, 2'd2, 1'b0, 32'd1022, 32'h0, 0);
        do_req("ill_0_err",   1'b0, 2'd3, 1'b0, 32'h0,   32'h0, 0);
        do_req("sw_1022_err", 1'b1, 2'd2, 1'b0, 32'd1022, 32'hDEADBEEF, 0);
        do_req("lh_1023_err", 1'b0, 2'd1, 1'b0, 32'd1023, 32'h0, 0);
        do_req("lw_top_err",  1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 0);
        do_req("lw_1020",     1'b0, 2'd2, 1'b0, 32'd1020, 32'h0, 0);
        do_req("sb_1023",     1'b1, 2'd0, 1'b0, 32'd1023, 32'h000000A5, 0);
        do_req("lbu_1023",    1'b0, 2'd0, 1'b1, 32'd1023, 32'h0, 0);
        do_req("lw_hold",     1'b0, 2'd2, 1'b0, 32'h0,   32'h0, 5);
        do_req("sh_hold",     1'b1, 2'd1, 1'b0, 32'h21,  32'h00001234, 3);

        // Reset during the read phase of a byte store: no write may follow.
        begin
            int wr0;
            int rd0;
            wr0 = wr_pulses;
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b1;
            bus.req_size  = 2'd0;
            bus.req_addr  = 32'h8;
            bus.req_wdata = 32'h00000055;
            @(posedge sys_clk);
            #1;
            bus.req_valid = 1'b0;
            chk("abort:mem_op_in_rd", 32'(bus.mem_op), 32'd1);
            rd0 = rd_pulses;
            #1 sys_rst = 1'b0;
            #1;
            chk_reset_outputs("abort");
            repeat (2) @(posedge sys_clk);
            @(negedge sys_clk);
            sys_rst = 1'b1;
            repeat (3) @(posedge sys_clk);
            #1;
            chk("abort:wr_pulses", 32'(wr_pulses - wr0), 32'd0);
            chk("abort:rd_pulses", 32'(rd_pulses - rd0), 32'd0);
            chk("abort:mem_word", mem_word(32'h8), ref_word(32'h8));
        end
        do_req("lbu_8_after", 1'b0, 2'd0, 1'b1, 32'h8, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameters: ADDR_WIDTH = 32, address width; DATA_WIDTH = 32, data width; SIZE = 1024, attached memory size in bytes.
REQ-002 sys_clk  in  1  single clock; all state updates on posedge.
REQ-003 sys_rst  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  request present. req_ready  out  1  request accepted when both are high at posedge.
REQ-005 req_we  in  1  0 = load, 1 = store. req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal. req_unsigned  in  1  zero-extend loads.
REQ-006 req_addr  in  ADDR_WIDTH  byte address. req_wdata  in  DATA_WIDTH  store data, low-order bytes used for byte/half.
REQ-007 rsp_valid  out  1  response present. rsp_ready  in  1  response consumed when both are high at posedge.
REQ-008 rsp_rdata  out  DATA_WIDTH  load result, extended to 32 bits. rsp_err  out  1  request rejected.
REQ-009 mem_op  out  1, mem_rw  out  1 (0 = read, 1 = write), mem_addr  out  ADDR_WIDTH, mem_data_w  out  DATA_WIDTH: memory request port. All are registered.
REQ-010 mem_data_r  in  DATA_WIDTH  memory read data. Little-endian byte lanes: lane 0 = byte at mem_addr. The memory acts on negedge and holds the result.

Function
REQ-011 FSM states: IDLE, RD, WR, RESP. req_ready = 1 only in IDLE.
REQ-012 On acceptance, latch addr, size, unsigned, we and wdata. req_* inputs are ignored outside IDLE.
REQ-013 Error when req_size == 3 or req_addr + nbytes > SIZE, where nbytes = 1/2/4. The sum is computed at ADDR_WIDTH+1 bits so there is no wrap. Next state is RESP with rsp_err = 1 and rsp_rdata = 0. No mem_op pulse.
REQ-014 Load: IDLE->RD->RESP. In RD: mem_op = 1, mem_rw = 0, mem_addr = latched addr. At the end of RD, capture mem_data_r. rsp_valid is first high 2 cycles after acceptance.
REQ-015 Load extraction uses lane 0 (byte) or lanes 1:0 (half). Sign-extend unless unsigned. A word load returns all 4 lanes unchanged.
REQ-016 Word store: IDLE->WR->RESP. In WR: mem_op = 1, mem_rw = 1, mem_data_w = wdata.
REQ-017 Byte/half store is read-modify-write: IDLE->RD->WR->RESP. At the end of RD, merge the captured data, replacing lane 0 (byte) or lanes 1:0 (half) with wdata. WR writes the merged word to the same address.
REQ-018 mem_op is high for exactly one cycle per RD or WR state and low in all other states. mem_rw, mem_addr and mem_data_w hold their last values when mem_op = 0.
REQ-019 RESP: rsp_valid = 1, with rsp_rdata and rsp_err stable until rsp_ready. The cycle after the handshake is IDLE. rsp_rdata = 0 for stores.
REQ-020 Back-to-back: a new request can be accepted in the cycle after a RESP handshake. At most one request is outstanding.
REQ-021 Unaligned in-range addresses are legal; the memory is byte-addressed and the block does not check alignment.

Reset
REQ-022 On sys_rst low, asynchronously: state = IDLE; req_ready = 1; rsp_valid, rsp_err, rsp_rdata, mem_op, mem_rw, mem_addr and mem_data_w = 0.
REQ-023 Reset asserted in RD or WR aborts the access with no response. mem_op drops immediately. A partial RMW write is not issued.

Structure
REQ-024 A shared package holds the size encodings (SZ_B/SZ_H/SZ_W/SZ_ILL), the FSM state encoding, and default widths.
REQ-025 One combinational sub-module, mem_lane_fmt, performs load extraction/extension and store merge; the FSM stays in mem_master.

Verification
REQ-026 Reset, then load word at 0x0, with word 0x00100513 preloaded -> rsp_rdata = 0x00100513, rsp_err = 0, rsp_valid 2 cycles after acceptance, one mem_op read pulse.
REQ-027 Byte 0x93 at 0x8: signed byte load -> 0xFFFFFF93. Unsigned byte load -> 0x00000093. Half load at 0x1, with bytes 0x05, 0x10 -> 0x00001005.
REQ-028 Word store 0x11223344 at 0x40, then half store 0xBEEF at 0x40, then word load at 0x40 -> 0x1122BEEF. The half store shows a read pulse followed by a write pulse with mem_data_w = 0x1122BEEF.
REQ-029 Word load at 1022 and req_size = 3 at 0x0 -> rsp_err = 1, rsp_rdata = 0, no mem_op pulse, rsp_valid 1 cycle after acceptance.
REQ-030 Hold rsp_ready low for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready low. Assert sys_rst during the RD of a byte store -> no write pulse, outputs at reset values, memory unchanged.
